// File: rtl/axi_burst_beat_gen.sv
// axi_burst_beat_gen
// Expands one AXI burst command (address, LEN, SIZE, BURST) into one record
// per data beat: beat address, byte-lane strobe, beat index and last flag.
// Unaligned start addresses, FIXED/INCR/WRAP bursts and illegal commands are
// handled; an illegal command yields a single error beat.
// Optional feature macro: AXI_BEAT_GEN_4K_CHECK_EN (INCR bursts crossing a
// 4KB page are flagged illegal).

module axi_burst_beat_gen #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 64,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [ADDR_WIDTH-1:0]    cmd_addr,
   input  logic [LEN_WIDTH-1:0]     cmd_len,
   input  logic [2:0]               cmd_size,
   input  logic [1:0]               cmd_burst,
   output logic                     beat_valid,
   input  logic                     beat_ready,
   output logic [ADDR_WIDTH-1:0]    beat_addr,
   output logic [DATA_WIDTH/8-1:0]  beat_strb,
   output logic [LEN_WIDTH-1:0]     beat_idx,
   output logic                     beat_last,
   output logic                     beat_err
);

   localparam int NB  = DATA_WIDTH / 8;
   localparam int NBL = $clog2(NB);
`ifdef AXI_BEAT_GEN_4K_CHECK_EN
   localparam int XW  = ADDR_WIDTH + LEN_WIDTH + 8;
`endif

   localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(NB - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1'b1);

   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;
   localparam logic [1:0] BURST_RSVD  = 2'd3;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Bytes per beat for a SIZE encoding.
   function automatic logic [ADDR_WIDTH-1:0] size_bytes(input logic [2:0] size);
      return ADDR_ONE << size;
   endfunction

   // Byte lane an address falls on within the data bus.
   function automatic int lane_of(input logic [ADDR_WIDTH-1:0] addr);
      return int'(addr & LANE_MASK);
   endfunction

   // Strobe with lanes lo..hi (inclusive) set.
   function automatic logic [NB-1:0] lane_range(input int lo, input int hi);
      logic [NB-1:0] m;
      m = '0;
      for (int i = 0; i < NB; i++) begin
         if ((i >= lo) && (i <= hi)) begin
            m[i] = 1'b1;
         end else begin
            m[i] = 1'b0;
         end
      end
      return m;
   endfunction

   // Registered state and burst context
   state_t                  state_r;
   logic                    beat_valid_r;
   logic [ADDR_WIDTH-1:0]   beat_addr_r;
   logic [NB-1:0]           beat_strb_r;
   logic [LEN_WIDTH-1:0]    beat_idx_r;
   logic                    beat_last_r;
   logic                    beat_err_r;
   logic [ADDR_WIDTH-1:0]   cur_r;      // aligned address of the presented beat
   logic [ADDR_WIDTH-1:0]   step_r;     // bytes per beat
   logic [ADDR_WIDTH-1:0]   wmask_r;    // wrap window size minus one
   logic [ADDR_WIDTH-1:0]   wbase_r;    // wrap boundary
   logic [1:0]              burst_r;
   logic [LEN_WIDTH-1:0]    len_r;

   // Next-state values
   state_t                  state_nx_s;
   logic                    beat_valid_nx_s;
   logic [ADDR_WIDTH-1:0]   beat_addr_nx_s;
   logic [NB-1:0]           beat_strb_nx_s;
   logic [LEN_WIDTH-1:0]    beat_idx_nx_s;
   logic                    beat_last_nx_s;
   logic                    beat_err_nx_s;
   logic [ADDR_WIDTH-1:0]   cur_nx_s;
   logic [ADDR_WIDTH-1:0]   step_nx_s;
   logic [ADDR_WIDTH-1:0]   wmask_nx_s;
   logic [ADDR_WIDTH-1:0]   wbase_nx_s;
   logic [1:0]              burst_nx_s;
   logic [LEN_WIDTH-1:0]    len_nx_s;

   // Command decode
   logic [ADDR_WIDTH-1:0]   s_s;
   logic [ADDR_WIDTH-1:0]   a_s;
   logic [ADDR_WIDTH-1:0]   w_s;
   logic [ADDR_WIDTH-1:0]   wmask_s;
   logic [ADDR_WIDTH-1:0]   wbase_s;
   logic [NB-1:0]           strb0_s;
   logic                    wrap_len_ok_s;
   logic                    page_err_s;
   logic                    illegal_s;
`ifdef AXI_BEAT_GEN_4K_CHECK_EN
   logic [XW-1:0]           last_byte_s;
`endif

   // Advance path
   logic [ADDR_WIDTH-1:0]   inc_addr_s;
   logic [ADDR_WIDTH-1:0]   nxt_addr_s;
   logic [NB-1:0]           nxt_strb_s;
   logic                    beat_hs_s;

   assign cmd_ready  = (state_r == IDLE) && !rst;
   assign beat_hs_s  = beat_valid_r && beat_ready;

   assign beat_valid = beat_valid_r;
   assign beat_addr  = beat_addr_r;
   assign beat_strb  = beat_strb_r;
   assign beat_idx   = beat_idx_r;
   assign beat_last  = beat_last_r;
   assign beat_err   = beat_err_r;

   // Decode the incoming command: beat size, alignment, wrap window, first strobe, legality
   always_comb begin
      s_s      = size_bytes(cmd_size);
      a_s      = cmd_addr & ~(s_s - ADDR_ONE);
      w_s      = s_s * (ADDR_WIDTH'(cmd_len) + ADDR_ONE);
      wmask_s  = w_s - ADDR_ONE;
      wbase_s  = cmd_addr & ~wmask_s;
      // First beat starts at the true byte address but ends on the aligned group end.
      strb0_s  = lane_range(lane_of(cmd_addr), lane_of(a_s) + int'(s_s) - 1);
      wrap_len_ok_s = (cmd_len == LEN_WIDTH'(1'd1)) || (cmd_len == LEN_WIDTH'(2'd3)) ||
                      (cmd_len == LEN_WIDTH'(3'd7)) || (cmd_len == LEN_WIDTH'(4'd15));
`ifdef AXI_BEAT_GEN_4K_CHECK_EN
      // Wide arithmetic so a burst running past the top of the address space is also caught.
      last_byte_s = XW'(a_s) + XW'(s_s) * (XW'(cmd_len) + XW'(1'b1)) - XW'(1'b1);
      if ((ADDR_WIDTH > 12) && (cmd_burst == BURST_INCR) &&
          ((last_byte_s >> 4'd12) != (XW'(cmd_addr) >> 4'd12))) begin
         page_err_s = 1'b1;
      end else begin
         page_err_s = 1'b0;
      end
`else
      page_err_s = 1'b0;
`endif
      illegal_s = (int'(cmd_size) > NBL) ||
                  (cmd_burst == BURST_RSVD) ||
                  ((cmd_burst == BURST_WRAP) && !wrap_len_ok_s) ||
                  ((cmd_burst == BURST_WRAP) && ((cmd_addr & (s_s - ADDR_ONE)) != '0)) ||
                  page_err_s;
   end

   // Address and strobe of the beat following the one currently presented
   always_comb begin
      inc_addr_s = cur_r + step_r;
      case (burst_r)
         BURST_INCR: nxt_addr_s = inc_addr_s;
         BURST_WRAP: nxt_addr_s = wbase_r | (inc_addr_s & wmask_r);
         default:    nxt_addr_s = cur_r;
      endcase
      nxt_strb_s = lane_range(lane_of(nxt_addr_s), lane_of(nxt_addr_s) + int'(step_r) - 1);
   end

   // FSM next-state and next beat record
   always_comb begin
      state_nx_s      = state_r;
      beat_valid_nx_s = beat_valid_r;
      beat_addr_nx_s  = beat_addr_r;
      beat_strb_nx_s  = beat_strb_r;
      beat_idx_nx_s   = beat_idx_r;
      beat_last_nx_s  = beat_last_r;
      beat_err_nx_s   = beat_err_r;
      cur_nx_s        = cur_r;
      step_nx_s       = step_r;
      wmask_nx_s      = wmask_r;
      wbase_nx_s      = wbase_r;
      burst_nx_s      = burst_r;
      len_nx_s        = len_r;
      case (state_r)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               state_nx_s      = RUN;
               beat_valid_nx_s = 1'b1;
               beat_addr_nx_s  = cmd_addr;
               beat_idx_nx_s   = '0;
               cur_nx_s        = a_s;
               step_nx_s       = s_s;
               wmask_nx_s      = wmask_s;
               wbase_nx_s      = wbase_s;
               burst_nx_s      = cmd_burst;
               len_nx_s        = cmd_len;
               if (illegal_s) begin
                  beat_strb_nx_s = '0;
                  beat_last_nx_s = 1'b1;
                  beat_err_nx_s  = 1'b1;
               end else begin
                  beat_strb_nx_s = strb0_s;
                  beat_last_nx_s = (cmd_len == '0);
                  beat_err_nx_s  = 1'b0;
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         RUN: begin
            if (beat_hs_s) begin
               if (beat_last_r) begin
                  state_nx_s      = IDLE;
                  beat_valid_nx_s = 1'b0;
               end else begin
                  beat_idx_nx_s  = beat_idx_r + LEN_WIDTH'(1'b1);
                  beat_last_nx_s = ((beat_idx_r + LEN_WIDTH'(1'b1)) == len_r);
                  cur_nx_s       = nxt_addr_s;
                  if (burst_r != BURST_FIXED) begin
                     beat_addr_nx_s = nxt_addr_s;
                     beat_strb_nx_s = nxt_strb_s;
                  end else begin
                     beat_addr_nx_s = beat_addr_r;
                     beat_strb_nx_s = beat_strb_r;
                  end
               end
            end else begin
               state_nx_s = RUN;
            end
         end
         default: begin
            state_nx_s      = IDLE;
            beat_valid_nx_s = 1'b0;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Beat record and burst context registers
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_valid_r <= 1'b0;
         beat_addr_r  <= '0;
         beat_strb_r  <= '0;
         beat_idx_r   <= '0;
         beat_last_r  <= 1'b0;
         beat_err_r   <= 1'b0;
         cur_r        <= '0;
         step_r       <= '0;
         wmask_r      <= '0;
         wbase_r      <= '0;
         burst_r      <= 2'd0;
         len_r        <= '0;
      end else begin
         beat_valid_r <= beat_valid_nx_s;
         beat_addr_r  <= beat_addr_nx_s;
         beat_strb_r  <= beat_strb_nx_s;
         beat_idx_r   <= beat_idx_nx_s;
         beat_last_r  <= beat_last_nx_s;
         beat_err_r   <= beat_err_nx_s;
         cur_r        <= cur_nx_s;
         step_r       <= step_nx_s;
         wmask_r      <= wmask_nx_s;
         wbase_r      <= wbase_nx_s;
         burst_r      <= burst_nx_s;
         len_r        <= len_nx_s;
      end
   end

endmodule

// File: doc/axi_burst_beat_gen.md
Name: axi_burst_beat_gen

Overview:
Parametrised AXI5 burst-to-beat expander for misaligned transfers. It accepts one burst command (address, LEN, SIZE, BURST) and emits one record per data beat, carrying the beat address, byte-lane strobe, beat index and last flag. Manager and subordinate BFM-side RTL use it to build and check WSTRB/RDATA lane usage. Unlike a fixed aligned-only interface, it handles unaligned start addresses, all three burst types and illegal-command detection.

Parameters:
ADDR_WIDTH, 16, address width in bits
DATA_WIDTH, 64, bus data width; power of two, 8..1024; NB = DATA_WIDTH/8 byte lanes
LEN_WIDTH, 8, width of the LEN field; a burst has LEN+1 beats

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready
cmd_addr  in  ADDR_WIDTH  start address, may be unaligned
cmd_len  in  LEN_WIDTH  beats minus one
cmd_size  in  3  log2 of bytes per beat
cmd_burst  in  2  0=FIXED, 1=INCR, 2=WRAP, 3=reserved
beat_valid  out  1  beat record valid
beat_ready  in  1  beat record accepted
beat_addr  out  ADDR_WIDTH  beat address
beat_strb  out  NB  active byte lanes
beat_idx  out  LEN_WIDTH  beat number, from 0
beat_last  out  1  final beat of the burst
beat_err  out  1  command illegal; the record carries no data

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on rst.
- While rst=1 the block forces: state IDLE, beat_valid=0, beat_addr=0, beat_strb=0, beat_idx=0, beat_last=0, beat_err=0. All beat outputs are registered.
- FSM has two states, IDLE and RUN.
  - cmd_ready=1 only in IDLE and only when rst=0.
  - The command handshake in cycle T moves the FSM to RUN. beat_valid=1 from cycle T+1, beat 0.
- In RUN, each beat_valid&&beat_ready handshake advances to the next beat; the next beat is valid the following cycle, so the block sustains 1 beat per cycle.
- The beat handshake on beat_last returns the FSM to IDLE. cmd_ready rises the next cycle; there is no same-cycle command overlap.
- While beat_valid=1 and beat_ready=0, all beat_* outputs hold stable.
- Arithmetic: S = 1<<cmd_size; A = cmd_addr aligned down to S.
  - Beat 0: beat_addr = cmd_addr unaligned; beat_strb sets lanes (cmd_addr mod NB) through ((A mod NB)+S-1).
  - INCR beat n>0: beat_addr = A + n*S, computed modulo 2^ADDR_WIDTH. beat_strb sets the S lanes starting at (beat_addr mod NB).
  - FIXED: every beat repeats beat 0's addr and strb.
  - WRAP: W = S*(LEN+1) and boundary B = cmd_addr aligned down to W. The address increments by S and wraps to B on reaching B+W. Strobes are full S-lane groups.
- Illegal command: any of S>NB, cmd_burst=3, WRAP with LEN+1 not in {2,4,8,16}, WRAP with cmd_addr not S-aligned, or a 4KB violation (see Optional Feature). Response: exactly one beat with beat_err=1, beat_strb=0, beat_last=1, beat_idx=0, beat_addr=cmd_addr.
- LEN=0: a single beat with beat_last=1.
- Reset mid-burst: the burst is abandoned; beat_valid=0 and cmd_ready=1 on the first cycle after rst deasserts.

Optional Feature:
- Macro AXI_BEAT_GEN_4K_CHECK_EN.
- Defined: an INCR burst whose last byte (A + (LEN+1)*S - 1) lies in a different 4KB page from cmd_addr is illegal (error beat). The check is inert when ADDR_WIDTH<=12.
- Undefined: no 4KB check; INCR addresses increment modulo 2^ADDR_WIDTH.

Test Plan:
- Use DATA_WIDTH=64 throughout.
- INCR, addr 0x0003, len 3, size 2 -> beats (0x0003, strb 0x08), (0x0004, 0xF0), (0x0008, 0x0F), (0x000C, 0xF0, last); idx 0..3; no err.
- WRAP, addr 0x0018, len 3, size 3 -> addresses 0x0018, 0x0000, 0x0008, 0x0010; strb 0xFF each; last on idx 3.
- FIXED, addr 0x0005, len 2, size 1 -> three beats, all addr 0x0005 and strb 0x20; last on idx 2.
- Illegal size 4 (16B) and separately burst=3 -> single beat, err=1, strb 0x00, last=1; cmd_ready=1 the cycle after that beat's handshake.
- Backpressure and reset:
  - Hold beat_ready=0 for 3 cycles at idx 1 of the first test -> outputs stable, then resume at 0x0008.
  - Assert rst at idx 2 -> beat_valid=0, then cmd_ready=1 after release.
- INCR, addr 0x0FF8, len 1, size 3 -> with AXI_BEAT_GEN_4K_CHECK_EN: one error beat. Without it: beats 0x0FF8 and 0x1000, strb 0xFF each.
